// File: rtl/coef_loader.sv
// Coefficient fetch stage: reads one layer's 16-bit weight block word by word
// from an external coefficient memory and assembles it into the weights bus.
module coef_loader #(
    parameter int FIRST_LAYER = 16,
    parameter int IMAGE_SIZE  = 64,
    parameter int ADDR_W      = 12
) (
    input  logic                                     clk,
    input  logic                                     n_rst,
    input  logic                                     request_coef,
    input  logic [1:0]                               coef_select,
    output logic                                     mem_ren,
    output logic [ADDR_W-1:0]                        mem_addr,
    input  logic                                     mem_rvalid,
    input  logic [15:0]                              mem_rdata,
    output logic [FIRST_LAYER-1:0][IMAGE_SIZE-1:0][15:0] weights,
    output logic                                     image_weights_loaded,
    output logic                                     busy,
    output logic                                     sel_error
);

    localparam int N      = FIRST_LAYER * IMAGE_SIZE;
    localparam int NODE_W = (FIRST_LAYER > 1) ? $clog2(FIRST_LAYER) : 1;
    localparam int INP_W  = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;

    localparam logic [NODE_W-1:0] LAST_NODE   = NODE_W'(FIRST_LAYER - 1);
    localparam logic [INP_W-1:0]  LAST_INP    = INP_W'(IMAGE_SIZE - 1);
    localparam logic [ADDR_W-1:0] BLOCK_WORDS = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] ROW_WORDS   = ADDR_W'(IMAGE_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                                     r_state;
    state_t                                     w_next_state;
    logic [1:0]                                 r_layer;
    logic [NODE_W-1:0]                          r_node;
    logic [INP_W-1:0]                           r_inp;
    logic [FIRST_LAYER-1:0][IMAGE_SIZE-1:0][15:0] r_weights;
    logic                                       r_sel_error;

    logic              w_start;
    logic              w_bad_sel;
    logic              w_capture;
    logic              w_last_word;
    logic [ADDR_W-1:0] w_addr;

    assign w_start     = (r_state == S_IDLE) && request_coef && (coef_select != 2'd3);
    assign w_bad_sel   = (r_state == S_IDLE) && request_coef && (coef_select == 2'd3);
    assign w_capture   = (r_state == S_WAIT) && mem_rvalid;
    assign w_last_word = (r_node == LAST_NODE) && (r_inp == LAST_INP);
    assign w_addr      = ADDR_W'(r_layer) * BLOCK_WORDS
                       + ADDR_W'(r_node) * ROW_WORDS
                       + ADDR_W'(r_inp);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_next_state         = r_state;
        mem_ren              = 1'b0;
        mem_addr             = '0;
        busy                 = 1'b0;
        image_weights_loaded = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_ren      = 1'b1;
                mem_addr     = w_addr;
                busy         = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (mem_rvalid) begin
                    w_next_state = w_last_word ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                image_weights_loaded = 1'b1;
                w_next_state         = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: the weight block is reset explicitly because the core must see an
    // all-zero block after reset, including after an aborted load.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_layer     <= '0;
            r_node      <= '0;
            r_inp       <= '0;
            r_weights   <= '0;
            r_sel_error <= 1'b0;
        end else begin
            r_sel_error <= w_bad_sel;
            if (w_start) begin
                r_layer <= coef_select;
                r_node  <= '0;
                r_inp   <= '0;
            end
            if (w_capture) begin
                r_weights[r_node][r_inp] <= mem_rdata;
                if (!w_last_word) begin
                    if (r_inp == LAST_INP) begin
                        r_inp  <= '0;
                        r_node <= r_node + NODE_W'(1);
                    end else begin
                        r_inp <= r_inp + INP_W'(1);
                    end
                end
            end
        end
    end

    assign weights   = r_weights;
    assign sel_error = r_sel_error;

endmodule

// File: tb/tb_coef_loader.sv
// Self-checking bench for coef_loader: a default-size instance with a
// data=address memory and a small instance with random contents and latency.
module tb_coef_loader;

    localparam int A_FL = 16, A_IS = 64, A_AW = 12, A_N = A_FL * A_IS;
    localparam int B_FL = 2,  B_IS = 4,  B_AW = 5,  B_N = B_FL * B_IS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- instance A: default parameters ----------------
    logic            a_rst, a_req, a_ren, a_rvalid, a_done, a_busy, a_selerr;
    logic [1:0]      a_sel;
    logic [A_AW-1:0] a_addr;
    logic [15:0]     a_rdata;
    logic [A_FL-1:0][A_IS-1:0][15:0] a_weights;

    coef_loader #(.FIRST_LAYER(A_FL), .IMAGE_SIZE(A_IS), .ADDR_W(A_AW)) u_dut_a (
        .clk(clk), .n_rst(a_rst), .request_coef(a_req), .coef_select(a_sel),
        .mem_ren(a_ren), .mem_addr(a_addr), .mem_rvalid(a_rvalid), .mem_rdata(a_rdata),
        .weights(a_weights), .image_weights_loaded(a_done), .busy(a_busy),
        .sel_error(a_selerr)
    );

    // ---------------- instance B: small block, variable latency ----------------
    logic            b_rst, b_req, b_ren, b_rvalid, b_done, b_busy, b_selerr;
    logic [1:0]      b_sel;
    logic [B_AW-1:0] b_addr;
    logic [15:0]     b_rdata;
    logic [B_FL-1:0][B_IS-1:0][15:0] b_weights;

    coef_loader #(.FIRST_LAYER(B_FL), .IMAGE_SIZE(B_IS), .ADDR_W(B_AW)) u_dut_b (
        .clk(clk), .n_rst(b_rst), .request_coef(b_req), .coef_select(b_sel),
        .mem_ren(b_ren), .mem_addr(b_addr), .mem_rvalid(b_rvalid), .mem_rdata(b_rdata),
        .weights(b_weights), .image_weights_loaded(b_done), .busy(b_busy),
        .sel_error(b_selerr)
    );

    // Memory A: data equals address, fixed programmable latency.
    int              a_lat = 1;
    bit              a_pend = 0;
    int              a_cnt;
    logic [A_AW-1:0] a_paddr;
    int              a_ren_count = 0;
    int              a_overlap = 0;
    logic [A_AW-1:0] a_addr_q[$];

    always @(negedge clk) begin
        a_rvalid = 1'b0;
        if (a_pend) begin
            a_cnt--;
            if (a_cnt == 0) begin
                a_rvalid = 1'b1;
                a_rdata  = 16'(a_paddr);
                a_pend   = 0;
            end
        end
        if (a_ren === 1'b1) begin
            if (a_pend) a_overlap++;
            a_pend  = 1;
            a_cnt   = a_lat;
            a_paddr = a_addr;
            a_ren_count++;
            a_addr_q.push_back(a_addr);
        end
    end

    // Memory B: random contents, random 1..4 cycle latency per read.
    logic [15:0]     b_mem[32];
    bit              b_pend = 0;
    int              b_cnt;
    logic [B_AW-1:0] b_paddr;
    int              b_overlap = 0;
    logic [B_AW-1:0] b_addr_q[$];
    int              b_lat_q[$];

    always @(negedge clk) begin
        b_rvalid = 1'b0;
        if (b_pend) begin
            b_cnt--;
            if (b_cnt == 0) begin
                b_rvalid = 1'b1;
                b_rdata  = b_mem[b_paddr];
                b_pend   = 0;
            end
        end
        if (b_ren === 1'b1) begin
            if (b_pend) b_overlap++;
            b_pend  = 1;
            b_cnt   = int'($urandom_range(1, 4));
            b_paddr = b_addr;
            b_lat_q.push_back(b_cnt);
            b_addr_q.push_back(b_addr);
        end
    end

    // Reference model of B's weight block, updated from the layout rule.
    logic [15:0] b_model[B_FL][B_IS];

    // Issue a request in cycle 0 (caller sits at a negedge) and watch until
    // the done pulse plus a few idle cycles, or until the budget expires.
    task automatic a_run(input logic [1:0] layer, output int done_cyc,
                         output int done_cnt, output logic busy1);
        done_cyc = -1; done_cnt = 0; busy1 = 1'b0;
        a_addr_q.delete(); a_ren_count = 0; a_overlap = 0;
        a_req = 1'b1; a_sel = layer;
        for (int t = 1; t <= 2 * A_N + 20; t++) begin
            @(negedge clk);
            a_req = 1'b0;
            if (t == 1) busy1 = a_busy;
            if (a_done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = t;
                    check("A_busy_in_done", a_busy, 0);
                end
            end
            if (done_cyc >= 0 && t >= done_cyc + 4) break;
        end
    endtask

    task automatic a_check_load(input string tag, input int layer);
        int bad_addr, bad_w;
        bad_addr = 0; bad_w = 0;
        check({tag, "_ren_count"}, a_ren_count, A_N);
        check({tag, "_overlap"}, a_overlap, 0);
        for (int k = 0; k < A_N && k < a_addr_q.size(); k++)
            if (int'(a_addr_q[k]) != layer * A_N + k) bad_addr++;
        check({tag, "_bad_addrs"}, bad_addr, 0);
        for (int n = 0; n < A_FL; n++)
            for (int i = 0; i < A_IS; i++)
                if (int'(a_weights[n][i]) != layer * A_N + n * A_IS + i) bad_w++;
        check({tag, "_bad_words"}, bad_w, 0);
    endtask

    task automatic b_run(input logic [1:0] layer, input int extra_at, output int done_cyc,
                         output int done_cnt, output logic busy1);
        done_cyc = -1; done_cnt = 0; busy1 = 1'b0;
        b_addr_q.delete(); b_lat_q.delete(); b_overlap = 0;
        b_req = 1'b1; b_sel = layer;
        for (int t = 1; t <= 200; t++) begin
            @(negedge clk);
            if (extra_at > 0 && t >= extra_at && t < extra_at + 3) begin
                b_req = 1'b1; b_sel = 2'd1;
            end else begin
                b_req = 1'b0; b_sel = layer;
            end
            if (t == 1) busy1 = b_busy;
            if (b_done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = t;
            end
            if (done_cyc >= 0 && t >= done_cyc + 4) break;
        end
        b_req = 1'b0;
    endtask

    task automatic b_check_load(input string tag, input int layer, input int done_cyc,
                                input int done_cnt, input logic busy1);
        int exp_done, bad_addr;
        exp_done = 1; bad_addr = 0;
        foreach (b_lat_q[k]) exp_done += 1 + b_lat_q[k];
        for (int n = 0; n < B_FL; n++)
            for (int i = 0; i < B_IS; i++)
                b_model[n][i] = b_mem[layer * B_N + n * B_IS + i];
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_cyc"}, done_cyc, exp_done);
        check({tag, "_busy_c1"}, busy1, 1);
        check({tag, "_n_reads"}, b_addr_q.size(), B_N);
        check({tag, "_overlap"}, b_overlap, 0);
        for (int k = 0; k < b_addr_q.size(); k++)
            if (int'(b_addr_q[k]) != layer * B_N + k) bad_addr++;
        check({tag, "_bad_addrs"}, bad_addr, 0);
        for (int n = 0; n < B_FL; n++)
            for (int i = 0; i < B_IS; i++)
                check($sformatf("%s_w%0d_%0d", tag, n, i), b_weights[n][i], b_model[n][i]);
    endtask

    initial begin
        int          dc, dn, cnt, sel_cnt, sel_cyc, ren_cnt, busy_cnt;
        logic        b1;
        logic [1:0]  lay;

        a_rst = 1'b1; a_req = 1'b0; a_sel = 2'd0;
        b_rst = 1'b1; b_req = 1'b0; b_sel = 2'd0;
        foreach (b_mem[k]) b_mem[k] = 16'($urandom);

        @(negedge clk);
        @(negedge clk);
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);

        // Reset values, cycle after release.
        check("A_rst_ren", a_ren, 0);
        check("A_rst_addr", a_addr, 0);
        check("A_rst_done", a_done, 0);
        check("A_rst_busy", a_busy, 0);
        check("A_rst_selerr", a_selerr, 0);
        cnt = 0;
        for (int n = 0; n < A_FL; n++)
            for (int i = 0; i < A_IS; i++)
                if (a_weights[n][i] !== 16'd0) cnt++;
        check("A_rst_nonzero_words", cnt, 0);
        check("B_rst_busy", b_busy, 0);
        check("B_rst_selerr", b_selerr, 0);
        check("B_rst_weights_zero", (b_weights === '0), 1);

        // Layer 0 full load with default parameters and 1-cycle memory.
        a_lat = 1;
        a_run(2'd0, dc, dn, b1);
        check("A_L0_done_cyc", dc, 2 * A_N + 1);
        check("A_L0_done_cnt", dn, 1);
        check("A_L0_busy_c1", b1, 1);
        a_check_load("A_L0", 0);

        // Reset mid-load: layer 2 with 2-cycle memory, reset in cycle 100.
        a_lat = 2;
        a_addr_q.delete();
        a_req = 1'b1; a_sel = 2'd2;
        for (int t = 1; t <= 100; t++) begin
            @(negedge clk);
            a_req = 1'b0;
        end
        check("A_abort_ren_c100", a_ren, 1);
        check("A_abort_addr_c100", a_addr, 2 * A_N + 33);
        check("A_abort_partial_w", a_weights[0][5], 2 * A_N + 5);
        a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
        check("A_abort_busy", a_busy, 0);
        check("A_abort_ren", a_ren, 0);
        check("A_abort_weights_zero", (a_weights === '0), 1);
        cnt = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (a_done === 1'b1 || a_busy === 1'b1) cnt++;
        end
        check("A_abort_no_activity", cnt, 0);
        check("A_abort_late_rvalid_ignored", (a_weights === '0), 1);

        a_lat = 1;
        a_run(2'd1, dc, dn, b1);
        check("A_L1_done_cyc", dc, 2 * A_N + 1);
        check("A_L1_done_cnt", dn, 1);
        a_check_load("A_L1", 1);

        // Layer 2 on the small instance with random latency.
        b_run(2'd2, 0, dc, dn, b1);
        b_check_load("B_L2", 2, dc, dn, b1);

        // Illegal select: one sel_error pulse, nothing else moves.
        b_addr_q.delete();
        sel_cnt = 0; sel_cyc = -1; ren_cnt = 0; busy_cnt = 0;
        b_req = 1'b1; b_sel = 2'd3;
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            b_req = 1'b0; b_sel = 2'd0;
            if (b_selerr === 1'b1) begin
                sel_cnt++;
                if (sel_cyc < 0) sel_cyc = t;
            end
            if (b_ren === 1'b1) ren_cnt++;
            if (b_busy === 1'b1) busy_cnt++;
        end
        check("B_ill_sel_cnt", sel_cnt, 1);
        check("B_ill_sel_cyc", sel_cyc, 1);
        check("B_ill_ren", ren_cnt, 0);
        check("B_ill_busy", busy_cnt, 0);
        for (int n = 0; n < B_FL; n++)
            for (int i = 0; i < B_IS; i++)
                check($sformatf("B_ill_w%0d_%0d", n, i), b_weights[n][i], b_model[n][i]);

        // Request for layer 1 arriving mid-load of layer 0 is ignored.
        foreach (b_mem[k]) b_mem[k] = 16'($urandom);
        b_run(2'd0, 5, dc, dn, b1);
        b_check_load("B_midreq", 0, dc, dn, b1);

        // Randomised loads with fresh memory contents.
        for (int r = 0; r < 4; r++) begin
            foreach (b_mem[k]) b_mem[k] = 16'($urandom);
            lay = 2'($urandom_range(0, 2));
            b_run(lay, 0, dc, dn, b1);
            b_check_load($sformatf("B_rnd%0d", r), int'(lay), dc, dn, b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
